// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues sequential word fetches, tags each request
// with its PC, buffers responses in an in-order FIFO for decode, and flushes
// both the buffer and in-flight responses when the branch unit redirects.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_pc_branch,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_instr,
    input  logic            i_id_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   fifo_rd_q, fifo_rd_d;
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic            started_q;

    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] tag_pc_q     [FIFO_DEPTH];

    logic [CW:0]     credit_used;
    logic            req;
    logic            grant_acc;
    logic            resp_ok;
    logic            resp_drop;
    logic            resp_keep;
    logic            pop;

    // The low target bits are dropped on purpose: misaligned targets trap elsewhere.
    logic unused_pc_low;
    assign unused_pc_low = ^i_pc_branch[1:0];

    // Credit check, handshake decode and next-state for all control counters.
    always_comb begin
        credit_used = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
        // Buffered plus in-flight never exceeds the buffer, so every response has a slot.
        req         = started_q && !i_branch_taken &&
                      (credit_used < (CW+1)'(FIFO_DEPTH));
        grant_acc   = req && i_imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp_ok     = i_imem_rvalid && (outstanding_q != '0);
        resp_drop   = resp_ok && (discard_q != '0);
        resp_keep   = resp_ok && (discard_q == '0) && !i_branch_taken;
        pop         = (fifo_cnt_q != '0) && i_id_ready;

        fetch_pc_d    = fetch_pc_q;
        fifo_cnt_d    = fifo_cnt_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;

        if (i_branch_taken) begin
            fetch_pc_d    = {i_pc_branch[XLEN-1:2], 2'b00};
            fifo_cnt_d    = '0;
            fifo_rd_d     = '0;
            fifo_wr_d     = '0;
            tag_rd_d      = '0;
            tag_wr_d      = '0;
            // Every response still in flight belongs to a dead path.
            outstanding_d = outstanding_q - CW'(resp_ok);
            discard_d     = outstanding_q - CW'(resp_ok);
        end else begin
            if (grant_acc) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tag_wr_d   = tag_wr_q + PW'(1);
            end
            // Discarded responses never had a tag, so only kept ones pop the queue.
            if (resp_keep) begin
                tag_rd_d  = tag_rd_q + PW'(1);
                fifo_wr_d = fifo_wr_q + PW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
            fifo_cnt_d    = fifo_cnt_q + CW'(resp_keep) - CW'(pop);
            outstanding_d = outstanding_q + CW'(grant_acc) - CW'(resp_ok);
            discard_d     = discard_q - CW'(resp_drop);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            started_q     <= 1'b1;
        end
    end

    // Tag and instruction storage; contents are only meaningful under the counters.
    always_ff @(posedge i_clk) begin
        if (grant_acc) begin
            tag_pc_q[tag_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            fifo_pc_q[fifo_wr_q]    <= tag_pc_q[tag_rd_q];
            fifo_instr_q[fifo_wr_q] <= i_imem_rdata;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc_q;
    assign o_if_valid  = (fifo_cnt_q != '0);
    assign o_if_pc     = o_if_valid ? fifo_pc_q[fifo_rd_q]    : '0;
    assign o_if_instr  = o_if_valid ? fifo_instr_q[fifo_rd_q] : '0;

`ifndef SYNTHESIS
    rvalid_needs_outstanding: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> (outstanding_q != '0)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model plus a path-level reference
// (next expected fetch address and next expected decode PC per path).
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br;
    logic [31:0] br_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ready;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_branch_taken(br), .i_pc_branch(br_pc),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_instr(if_instr),
        .i_id_ready(ready)
    );

    int checks = 0;
    int failures = 0;

    // stimulus controls
    bit          br_ctl;
    logic [31:0] br_tgt;
    bit          ready_ctl;
    int          gnt_mode;
    int          lat_min, lat_max;
    int          wh_left;
    logic [31:0] wh_addr;

    // memory model and reference state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc;
    logic [31:0] exp_pc, exp_addr;
    bit          prev_stall, prev_br;
    logic [31:0] prev_addr;

    // per-step observations
    bit          s_req, s_valid, s_grant, s_xfer;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [31:0] last_grant_addr, last_xfer_pc;
    int          n_grants, n_xfers;

    task automatic reset_model();
        mq_addr.delete();
        mq_due.delete();
        exp_pc = 32'h0; exp_addr = 32'h0;
        prev_stall = 0; prev_br = 0; prev_addr = 0;
        br_ctl = 0; br_tgt = 0; br = 0; br_pc = 0;
        gnt = 0; rvalid = 0; rdata = 0;
        n_grants = 0; n_xfers = 0;
        gnt_mode = 0; lat_min = 1; lat_max = 1; wh_left = 0; wh_addr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        reset_model();
        ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, check path rules.
    task automatic step();
        @(negedge clk);
        br = br_ctl; br_pc = br_tgt; ready = ready_ctl;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rvalid = 1;
            rdata  = mq_addr[0] ^ KEY;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            rvalid = 0;
            rdata  = $urandom;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr;
        s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
        if (wh_left > 0 && s_req && s_addr == wh_addr) begin
            gnt = 0; wh_left--;
        end else if (gnt_mode == 1) gnt = 1'($urandom_range(0, 1));
        else gnt = 1;
        #1;
        s_grant = s_req && gnt;
        s_xfer  = s_valid && ready;
        checks++;
        if (br && s_req) begin
            failures++; $display("FAIL req_during_redirect: req=%0b required 0", s_req);
        end
        if (prev_br) begin
            checks++;
            if (s_valid !== 1'b0) begin
                failures++; $display("FAIL valid_after_redirect: valid=%0b required 0", s_valid);
            end
        end
        if (prev_stall && !br) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== prev_addr) begin
                failures++;
                $display("FAIL addr_hold: req=%0b addr=%h required req=1 addr=%h", s_req, s_addr, prev_addr);
            end
        end
        if (s_xfer) begin
            checks++;
            if (s_pc !== exp_pc || s_instr !== (exp_pc ^ KEY)) begin
                failures++;
                $display("FAIL decode_pair: pc=%h instr=%h required pc=%h instr=%h",
                         s_pc, s_instr, exp_pc, exp_pc ^ KEY);
            end
            last_xfer_pc = s_pc;
            exp_pc = exp_pc + 32'd4;
            n_xfers++;
        end
        if (s_grant) begin
            checks++;
            if (s_addr !== exp_addr) begin
                failures++; $display("FAIL fetch_addr: addr=%h required %h", s_addr, exp_addr);
            end
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + $urandom_range(lat_min, lat_max));
            last_grant_addr = s_addr;
            exp_addr = exp_addr + 32'd4;
            n_grants++;
        end
        if (br) begin
            exp_pc   = {br_pc[31:2], 2'b00};
            exp_addr = {br_pc[31:2], 2'b00};
        end
        prev_br = br;
        prev_stall = s_req && !gnt;
        prev_addr = s_addr;
        cyc++;
    endtask

    task automatic wait_xfer(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = s_xfer;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no transfer within 40 cycles, required one", name);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        reset_model();
        ready = 1;
        #2;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%0b valid=%0b pc=%h instr=%h required all 0",
                     imem_req, if_valid, if_pc, if_instr);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_stream();
        int bubbles = 0;
        do_reset();
        ready_ctl = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i >= 3 && !s_valid) bubbles++;
        end
        checks++;
        if (bubbles != 0 || n_xfers < 21) begin
            failures++;
            $display("FAIL stream_rate: bubbles=%0d xfers=%0d required 0 and >=21", bubbles, n_xfers);
        end
    endtask

    task automatic test_ready_low();
        bit got;
        do_reset();
        ready_ctl = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 4) begin
                checks++;
                if (s_req !== 1'b0) begin
                    failures++; $display("FAIL credit_stop: cycle %0d req=%0b required 0", i, s_req);
                end
            end
            if (s_valid) begin
                checks++;
                if (s_pc !== 32'h0) begin
                    failures++; $display("FAIL head_stable: pc=%h required 0", s_pc);
                end
            end
        end
        checks++;
        if (n_grants != 4 || !s_valid) begin
            failures++; $display("FAIL credit_count: grants=%0d valid=%0b required 4 and 1", n_grants, s_valid);
        end
        ready_ctl = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = s_grant;
        end
        checks++;
        if (!got || last_grant_addr !== 32'h10) begin
            failures++; $display("FAIL resume_addr: got=%0b addr=%h required 00000010", got, last_grant_addr);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_gnt_withhold();
        int stalls = 0;
        do_reset();
        ready_ctl = 1;
        wh_addr = 32'h8; wh_left = 3;
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_req && !gnt && s_addr == 32'h8) stalls++;
        end
        checks++;
        if (stalls != 3 || n_xfers < 6) begin
            failures++; $display("FAIL gnt_withhold: stalls=%0d xfers=%0d required 3 and >=6", stalls, n_xfers);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        do_reset();
        ready_ctl = 1; lat_min = 2; lat_max = 2;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = s_grant && last_grant_addr == 32'h14;
        end
        checks++;
        if (!ok || mq_addr.size() != 2) begin
            failures++; $display("FAIL redirect_setup: ok=%0b outstanding=%0d required 1 and 2", ok, mq_addr.size());
        end
        br_ctl = 1; br_tgt = 32'h100;
        step();
        br_ctl = 0;
        wait_xfer("redirect", ok);
        if (ok) begin
            checks++;
            if (last_xfer_pc !== 32'h100) begin
                failures++; $display("FAIL redirect_first: pc=%h required 00000100", last_xfer_pc);
            end
        end
        wait_xfer("redirect_next", ok);
        if (ok) begin
            checks++;
            if (last_xfer_pc !== 32'h104) begin
                failures++; $display("FAIL redirect_second: pc=%h required 00000104", last_xfer_pc);
            end
        end
        br_ctl = 1; br_tgt = 32'h203;
        step();
        br_ctl = 0;
        step();
        checks++;
        if (s_addr !== 32'h200) begin
            failures++; $display("FAIL redirect_align: addr=%h required 00000200", s_addr);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        ready_ctl = 1; lat_min = 4; lat_max = 4;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = (mq_addr.size() == 3);
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL b2b_setup: outstanding=%0d required 3", mq_addr.size());
        end
        br_ctl = 1; br_tgt = 32'h40;
        step();
        br_tgt = 32'h80;
        step();
        br_ctl = 0;
        wait_xfer("b2b", ok);
        if (ok) begin
            checks++;
            if (last_xfer_pc !== 32'h80) begin
                failures++; $display("FAIL b2b_first: pc=%h required 00000080", last_xfer_pc);
            end
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_random();
        do_reset();
        gnt_mode = 1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 500; i++) begin
            ready_ctl = 1'($urandom_range(0, 1));
            br_ctl = ($urandom_range(0, 99) < 4);
            br_tgt = $urandom;
            step();
        end
        br_ctl = 0; ready_ctl = 1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (n_xfers < 50) begin
            failures++; $display("FAIL random_progress: xfers=%0d required >=50", n_xfers);
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        do_reset();
        ready_ctl = 0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (s_valid !== 1'b1) begin
            failures++; $display("FAIL mid_fill: valid=%0b required 1", s_valid);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: req=%0b valid=%0b pc=%h instr=%h required all 0",
                     imem_req, if_valid, if_pc, if_instr);
        end
        reset_model();
        @(negedge clk);
        rst_n = 1;
        ready_ctl = 1;
        wait_xfer("mid_refetch", ok);
        if (ok) begin
            checks++;
            if (last_xfer_pc !== 32'h0) begin
                failures++; $display("FAIL mid_refetch: pc=%h required 00000000", last_xfer_pc);
            end
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        rst_n = 1; ready = 0; ready_ctl = 0; cyc = 0;
        last_grant_addr = 0; last_xfer_pc = 0;
        reset_model();
        test_reset();
        test_stream();
        test_ready_low();
        test_gnt_withhold();
        test_redirect();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
